keypad_encoder: RTL and testbench
=================================

# keypad_encoder

Scans a 4x4 active-low matrix keypad, debounces the pressed key and produces the 5-bit code that drives the segment decoder's A..E inputs. It is the input end of the display path: keypad_encoder writes the code and the display decoder reads it. CODE[4] flags a held key and CODE[3:0] gives the key index. A one-cycle VALID strobe marks each new accepted press.

## Interface
- SCAN_CYCLES, default 4: clocks each row stays driven before COL is sampled (2..255).
- DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a press or a release (1..65535).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- COL  in  4  keypad column sense, active-low (pulled up), asynchronous to clk.
- ROW  out 4  keypad row drive, active-low, one-hot-zero.
- CODE out 5  {held, row[1:0], col[1:0]}; maps to decoder inputs A=CODE[4] .. E=CODE[0].
- VALID out 1 one-cycle pulse when a new press is accepted.
- HELD out 1  level; high from accept to release accept (equals CODE[4]).

## Operation
- COL passes through a 2-flop synchronizer. All logic uses the synchronized value colS. Input-to-logic delay is 2 cycles.
- Key index is row*4+col. With several columns low, the lowest column index wins.
- States: SCAN, DEBOUNCE, PRESSED, RELEASE.
- SCAN: drive ROW low for row r for SCAN_CYCLES cycles, then sample colS on the last dwell cycle.
  - colS == 4'hF: advance r (3 wraps to 0) and restart the dwell.
  - Otherwise: latch r and the winning col into the candidate, latch the colS pattern, clear the counter and go to DEBOUNCE. ROW stays on r.
- DEBOUNCE: each cycle, compare colS with the latched pattern.
  - Equal: increment the counter. When the counter reaches DEBOUNCE_CYCLES, load CODE <= {1, r, col}, pulse VALID, set HELD and go to PRESSED.
  - Different: return to SCAN at row r+1, with no output change.
- PRESSED: ROW stays on r. If colS[col] goes high, clear the counter and go to RELEASE. Other columns going low are ignored.
- RELEASE:
  - colS[col] high: increment the counter. At DEBOUNCE_CYCLES, clear CODE[4] and HELD and go to SCAN at row r+1. CODE[3:0] keeps the last key.
  - colS[col] low again: return to PRESSED with no output change.
- Only one key is tracked at a time. A second key pressed during PRESSED or RELEASE is not reported until the first is released and the second is found on a later scan.
- Counter width is $clog2(DEBOUNCE_CYCLES+1) and it saturates. The dwell counter is $clog2(SCAN_CYCLES) bits.

## Timing
- Reset values (asynchronous, immediate): ROW=4'b1110 (row 0), CODE=5'b00000, VALID=0, HELD=0, state SCAN, all counters 0, synchronizer flops 4'hF.
- Reset mid-press drops the key with no VALID. After reset, a still-held key is re-detected on a normal scan and reported.
- Scan period when idle: 4*SCAN_CYCLES cycles.
- Press latency: let t0 be the dwell-sample cycle that first sees a low column.
  - VALID is high in cycle t0+DEBOUNCE_CYCLES+1, when CODE and HELD update.
  - Worst case from the physical edge is 2 + 4*SCAN_CYCLES + DEBOUNCE_CYCLES + 1 cycles.
- Release latency: with t1 the first cycle colS[col]=1, HELD falls in cycle t1+DEBOUNCE_CYCLES+1.
- VALID is exactly one cycle per accepted press and is never asserted on release.
- ROW changes only at dwell boundaries in SCAN and on a release-accept or debounce abort. It never changes during DEBOUNCE, PRESSED or RELEASE.

## Structure
- Shared package keypad_pkg holds:
  - state enum kp_state_t {SCAN, DEBOUNCE, PRESSED, RELEASE};
  - localparam CODE_W=5;
  - ROW_RESET=4'b1110;
  - COL_IDLE=4'hF.
- Sub-module sync2 (parameterized width, reset value) is the COL synchronizer. It is reusable for other asynchronous board inputs.
- FSM, dwell counter, debounce counter and priority encoder live in keypad_encoder.

## Test plan
- Idle scan: after reset with COL=4'hF, ROW cycles 1110→1101→1011→0111→1110 every SCAN_CYCLES. CODE stays 0 and VALID never fires.
- Clean press at row 2, col 1, held 50 cycles then released (DEBOUNCE_CYCLES=16): one VALID pulse with CODE=5'b11001, HELD=1. After release plus 17 cycles, HELD=0 and CODE=5'b01001.
- Bounce: toggle COL[1] every 5 cycles for 40 cycles on row 0, then hold low. There is no VALID during bouncing and exactly one VALID with CODE=5'b10001 after the stable press.
- Two columns low (COL=4'b0011 on row 3): CODE=5'b11110 (col 2). Pressing a second key during PRESSED produces no extra VALID.
- Reset asserted during PRESSED: outputs immediately return to the reset values. With the key still held after reset release, one new VALID appears after a scan plus debounce.
- Release glitch: during RELEASE, drop COL[col] low for 1 cycle at count 8. HELD stays 1, there is no VALID, and release completes only after 16 clean cycles.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and constants for the matrix keypad front end.
//   kp_state_t : scanner FSM states (SCAN, DEBOUNCE, PRESSED, RELEASE)
//   CODE_W     : width of the code word handed to the display decoder
//   ROW_RESET  : row drive pattern after reset (row 0 driven low)
//   COL_IDLE   : column sense value with no key pressed (pull-ups)
//   low_col()  : index of the lowest-numbered active-low column
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam int         CODE_W    = 5;
  localparam logic [3:0] ROW_RESET = 4'b1110;
  localparam logic [3:0] COL_IDLE  = 4'hF;

  // Lowest column index wins when several columns are pulled low.
  function automatic logic [1:0] low_col(input logic [3:0] cols);
    logic [1:0] idx;
    casez (cols)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_encoder_if.sv
// keypad_encoder_if
// Bundles the keypad matrix lines and the code word toward the display decoder.
//   COL   : column sense, active-low, asynchronous to the system clock
//   ROW   : row drive, active-low, at most one row low
//   CODE  : {held, row[1:0], col[1:0]}
//   VALID : one-cycle strobe for each newly accepted press
//   HELD  : level, high while the accepted key is still down
// master = keypad_encoder side, slave = keypad/decoder side.
interface keypad_encoder_if;
  import keypad_pkg::*;

  logic [3:0]        COL;
  logic [3:0]        ROW;
  logic [CODE_W-1:0] CODE;
  logic              VALID;
  logic              HELD;

  modport master (
    input  COL,
    output ROW,
    output CODE,
    output VALID,
    output HELD
  );

  modport slave (
    output COL,
    input  ROW,
    input  CODE,
    input  VALID,
    input  HELD
  );

endinterface

// File: rtl/sync2.sv
// sync2
// Two-flop synchronizer for asynchronous board inputs.
//   clk : destination clock
//   rst : asynchronous active-high reset, loads RESET_VAL into both stages
//   d   : asynchronous input
//   q   : synchronized output, two clocks behind d
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] stable;

  // Reset to the idle level so downstream logic never sees a false event
  // while the first real samples propagate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= RESET_VAL;
      stable <= RESET_VAL;
    end else begin
      meta   <= d;
      stable <= meta;
    end
  end

  assign q = stable;

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder
// Scans a 4x4 active-low keypad matrix, debounces one key at a time and
// produces the 5-bit code {held, row, col} for the segment decoder.
//   clk : system clock
//   rst : asynchronous active-high reset
//   kp  : keypad_encoder_if.master (COL in; ROW, CODE, VALID, HELD out)
// Parameters:
//   SCAN_CYCLES     : clocks each row is driven before columns are sampled (2..255)
//   DEBOUNCE_CYCLES : consecutive stable clocks to accept a press or release (1..65535)
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  keypad_encoder_if.master kp
);

  localparam int DWELL_W = $clog2(SCAN_CYCLES);
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(DEBOUNCE_CYCLES);

  localparam logic [1:0] S_SCAN     = SCAN;
  localparam logic [1:0] S_DEBOUNCE = DEBOUNCE;
  localparam logic [1:0] S_PRESSED  = PRESSED;
  localparam logic [1:0] S_RELEASE  = RELEASE;

  logic [1:0]         state;
  logic [1:0]         row_idx;
  logic [3:0]         row_drive;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DEB_W-1:0]   deb_cnt;
  logic [1:0]         cand_col;
  logic [3:0]         col_pat;
  logic [CODE_W-1:0]  code_q;
  logic               valid_q;
  logic               held_q;

  logic [3:0]         col_s;
  logic [DEB_W-1:0]   deb_inc;
  logic               deb_done;
  logic               key_up;

  sync2 #(
    .WIDTH     (4),
    .RESET_VAL (COL_IDLE)
  ) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (kp.COL),
    .q   (col_s)
  );

  // Saturating debounce count; "done" means this cycle's increment reaches
  // DEBOUNCE_CYCLES, so the outputs update on the following edge.
  assign deb_inc  = (deb_cnt == DEB_MAX) ? DEB_MAX : deb_cnt + DEB_W'(1);
  assign deb_done = (deb_inc == DEB_MAX);

  // Only the tracked column matters once a key is accepted; other columns
  // on the same row are ignored until the scan resumes.
  assign key_up = col_s[cand_col];

  // Scanner FSM. ROW only moves at a dwell boundary in SCAN, on a debounce
  // abort, or on release accept; in every case it steps to the next row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_SCAN;
      row_idx   <= 2'd0;
      row_drive <= ROW_RESET;
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      cand_col  <= 2'd0;
      col_pat   <= COL_IDLE;
      code_q    <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        S_SCAN: begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            if (col_s == COL_IDLE) begin
              row_idx   <= row_idx + 2'd1;
              row_drive <= {row_drive[2:0], row_drive[3]};
            end else begin
              cand_col <= low_col(col_s);
              col_pat  <= col_s;
              deb_cnt  <= '0;
              state    <= S_DEBOUNCE;
            end
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end
        end

        S_DEBOUNCE: begin
          if (col_s == col_pat) begin
            deb_cnt <= deb_inc;
            if (deb_done) begin
              code_q  <= {1'b1, row_idx, cand_col};
              valid_q <= 1'b1;
              held_q  <= 1'b1;
              state   <= S_PRESSED;
            end
          end else begin
            dwell_cnt <= '0;
            row_idx   <= row_idx + 2'd1;
            row_drive <= {row_drive[2:0], row_drive[3]};
            state     <= S_SCAN;
          end
        end

        S_PRESSED: begin
          if (key_up) begin
            deb_cnt <= '0;
            state   <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          if (key_up) begin
            deb_cnt <= deb_inc;
            if (deb_done) begin
              code_q[CODE_W-1] <= 1'b0;
              held_q           <= 1'b0;
              dwell_cnt        <= '0;
              row_idx          <= row_idx + 2'd1;
              row_drive        <= {row_drive[2:0], row_drive[3]};
              state            <= S_SCAN;
            end
          end else begin
            state <= S_PRESSED;
          end
        end

        default: state <= S_SCAN;
      endcase
    end
  end

  assign kp.ROW   = row_drive;
  assign kp.CODE  = code_q;
  assign kp.VALID = valid_q;
  assign kp.HELD  = held_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder
// Self-checking bench for keypad_encoder. A behavioural 4x4 matrix turns the
// pressed-key vector and the DUT row drive into column levels. Expected press
// and release codes are queued when keys are driven and popped by a monitor
// when VALID pulses or HELD falls.
module tb_keypad_encoder;
  import keypad_pkg::*;

  localparam int SC = 4;
  localparam int DC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  keypad_encoder_if kp_bus ();

  logic [15:0] keys;
  logic [3:0]  col_model;

  // A pressed key pulls its column low only while its row is driven.
  always_comb begin
    col_model = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp_bus.ROW[r]) col_model[c] = 1'b0;
  end

  assign kp_bus.COL = col_model;

  keypad_encoder #(
    .SCAN_CYCLES     (SC),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_bus)
  );

  int total;
  int bad;

  logic [4:0] press_q[$];
  logic [4:0] release_q[$];

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor: pairs each VALID with a queued press code and each HELD fall
  // with a queued release code; also checks VALID lasts a single cycle.
  logic       held_prev;
  logic       valid_prev;
  logic [4:0] mon_code;

  initial begin
    held_prev  = 1'b0;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_prev  = 1'b0;
        valid_prev = 1'b0;
      end else begin
        if (valid_prev) check_output("valid_width", kp_bus.VALID, 1'b0);
        if (kp_bus.VALID) begin
          if (press_q.size() == 0) begin
            check_output("spurious_valid", kp_bus.VALID, 1'b0);
          end else begin
            mon_code = press_q.pop_front();
            check_output("press_code", kp_bus.CODE, mon_code);
            check_output("press_held", kp_bus.HELD, 1'b1);
          end
        end
        if (held_prev && !kp_bus.HELD) begin
          if (release_q.size() == 0) begin
            check_output("spurious_release", kp_bus.HELD, 1'b1);
          end else begin
            mon_code = release_q.pop_front();
            check_output("release_code", kp_bus.CODE, mon_code);
          end
        end
        held_prev  = kp_bus.HELD;
        valid_prev = kp_bus.VALID;
      end
    end
  end

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!kp_bus.VALID && cycles < budget);
    check_output("valid_seen", kp_bus.VALID, 1'b1);
  endtask

  task automatic press_key(input int idx, input logic [4:0] code, input int budget, output int lat);
    logic [3:0] row_exp;
    row_exp = ~(4'b0001 << (idx / 4));
    press_q.push_back(code);
    keys[idx] = 1'b1;
    wait_valid(budget, lat);
    check_output("press_row", kp_bus.ROW, row_exp);
  endtask

  // Releases every key at a negedge; HELD must fall exactly DC+3 clock
  // edges later (2 synchronizer stages, 1 to enter RELEASE, DC counts).
  task automatic release_all(input logic [4:0] code, input logic [3:0] row_after);
    release_q.push_back(code);
    keys = '0;
    repeat (DC + 2) @(negedge clk);
    check_output("release_early", kp_bus.HELD, 1'b1);
    @(negedge clk);
    check_output("release_held", kp_bus.HELD, 1'b0);
    check_output("release_row", kp_bus.ROW, row_after);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         lat;
    logic [3:0] row_exp;

    total = 0;
    bad   = 0;
    keys  = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check_output("rst_row", kp_bus.ROW, 4'b1110);
    check_output("rst_code", kp_bus.CODE, 5'b00000);
    check_output("rst_valid", kp_bus.VALID, 1'b0);
    check_output("rst_held", kp_bus.HELD, 1'b0);
    rst = 1'b0;

    // Idle scan: row k/SC is driven after k clocks
    for (int k = 1; k <= 5 * SC; k++) begin
      @(negedge clk);
      row_exp = ~(4'b0001 << ((k / SC) % 4));
      check_output("idle_row", kp_bus.ROW, row_exp);
    end
    check_output("idle_code", kp_bus.CODE, 5'b00000);

    // Clean press row 2 col 1, held, then released
    press_key(9, 5'b11001, 4 * SC + DC + 10, lat);
    check_output("press_lat_min", lat >= DC + 3, 1'b1);
    check_output("press_lat_max", lat <= 4 * SC + DC + 3, 1'b1);
    repeat (49) @(negedge clk);
    check_output("hold_held", kp_bus.HELD, 1'b1);
    check_output("hold_code", kp_bus.CODE, 5'b11001);
    release_all(5'b01001, 4'b0111);
    check_output("after_release_code", kp_bus.CODE, 5'b01001);

    // Bounce on row 0 col 1, then stable press
    for (int i = 0; i < 8; i++) begin
      keys[1] = ~keys[1];
      repeat (5) @(negedge clk);
    end
    press_key(1, 5'b10001, 4 * SC + DC + 20, lat);
    repeat (10) @(negedge clk);
    release_all(5'b00001, 4'b1101);

    // Two columns low on row 3, then a second key during PRESSED
    keys[15] = 1'b1;
    press_key(14, 5'b11110, 4 * SC + DC + 20, lat);
    repeat (5) @(negedge clk);
    keys[4] = 1'b1;
    repeat (40) @(negedge clk);
    check_output("second_key_held", kp_bus.HELD, 1'b1);
    check_output("second_key_code", kp_bus.CODE, 5'b11110);
    release_all(5'b01110, 4'b1110);

    // Reset while PRESSED, key still held afterwards
    press_key(7, 5'b10111, 4 * SC + DC + 20, lat);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("rst_mid_row", kp_bus.ROW, 4'b1110);
    check_output("rst_mid_code", kp_bus.CODE, 5'b00000);
    check_output("rst_mid_valid", kp_bus.VALID, 1'b0);
    check_output("rst_mid_held", kp_bus.HELD, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    press_q.push_back(5'b10111);
    wait_valid(4 * SC + DC + 10, lat);
    // Row 1 is sampled on its last dwell clock (2*SC-1), VALID DC+1 later.
    check_output("redetect_lat", lat, 2 * SC + DC);
    release_all(5'b00111, 4'b1011);

    // Release glitch: one low clock at release count 8
    press_key(0, 5'b10000, 4 * SC + DC + 20, lat);
    repeat (10) @(negedge clk);
    release_q.push_back(5'b00000);
    keys[0] = 1'b0;
    repeat (9) @(negedge clk);
    keys[0] = 1'b1;
    @(negedge clk);
    keys[0] = 1'b0;
    repeat (9) @(negedge clk);
    check_output("glitch_hold_a", kp_bus.HELD, 1'b1);
    repeat (9) @(negedge clk);
    check_output("glitch_hold_b", kp_bus.HELD, 1'b1);
    @(negedge clk);
    check_output("glitch_release", kp_bus.HELD, 1'b0);
    check_output("glitch_code", kp_bus.CODE, 5'b00000);

    repeat (4 * SC + 4) @(negedge clk);
    check_output("press_q_empty", press_q.size(), 0);
    check_output("release_q_empty", release_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
